// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM states and op classification helpers for muldiv_unit
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_IT = 2'd1,
        DIV_IT = 2'd2
    } state_e;

    // Multiply-class ops: anything that produces a 2*WIDTH product.
    function automatic logic is_mul_op(input logic [3:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    // Ops that interpret their operands as two's complement.
    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// rtl/muldiv_unit_div_step.sv - one unsigned restoring-division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // quo holds the unconsumed dividend bits at the top and the quotient
    // bits built so far at the bottom; one dividend bit moves into rem.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    // rem < dvs keeps shifted < 2*dvs, so diff[WIDTH] is a clean borrow flag.
    assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit owning the HI/LO pair
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [3:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iFlush,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int W2 = 2 * WIDTH;

    state_e           state, state_next;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] dvs_q;          // divisor, or multiplicand for the shift-add multiplier
    logic [WIDTH-1:0] wk_hi, wk_lo;   // partial remainder/quotient, or partial product
    logic             q_neg, r_neg, b_zero, done_q;

    logic             accept, in_mul, in_div, sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_n, quo_n, div_hi, div_lo;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [W2-1:0]    mul_prod;

    assign in_mul = is_mul_op(iOp);
    assign in_div = is_div_op(iOp);
    assign sgn    = is_signed_op(iOp);
    assign accept = iStart && (state == IDLE) && !iFlush;

    assign a_mag = (sgn && iA[WIDTH-1]) ? -iA : iA;
    assign b_mag = (sgn && iB[WIDTH-1]) ? -iB : iB;

    assign oBusy = (state != IDLE);
    assign oDone = done_q;
    assign oHI   = hi;
    assign oLO   = lo;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (wk_hi),
        .quo      (wk_lo),
        .dvs      (dvs_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    // Sign fix-up on the final step; divide-by-zero overrides with fixed values.
    // Most-negative / -1 needs no special case: magnitude 2^(W-1) / 1 wraps back.
    assign div_lo = b_zero ? '1  : (q_neg ? -quo_n : quo_n);
    assign div_hi = b_zero ? a_q : (r_neg ? -rem_n : rem_n);

    generate
        if (FAST_MUL) begin : g_fast
            logic [W2-1:0] ext_a, ext_b;
            assign ext_a    = {{WIDTH{sgn & iA[WIDTH-1]}}, iA};
            assign ext_b    = {{WIDTH{sgn & iB[WIDTH-1]}}, iB};
            assign mul_prod = ext_a * ext_b;
            assign mul_hi_n = '0;
            assign mul_lo_n = '0;
        end else begin : g_iter
            // Shift-add on magnitudes: add multiplicand when the low bit is set, then shift right.
            logic [WIDTH:0] sum;
            assign sum      = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, dvs_q} : '0);
            assign mul_hi_n = sum[WIDTH:1];
            assign mul_lo_n = {sum[0], wk_lo[WIDTH-1:1]};
            assign mul_prod = q_neg ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
        end
    endgenerate

    // Fold a product into the HI/LO pair according to the op.
    function automatic logic [W2-1:0] mac(input logic [3:0] op,
                                          input logic [W2-1:0] acc,
                                          input logic [W2-1:0] prod);
        case (op)
            OP_MADD, OP_MADDU: return acc + prod;
            OP_MSUB, OP_MSUBU: return acc - prod;
            default:           return prod;
        endcase
    endfunction

    // State register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state: iterative ops leave IDLE on accept; flush or counter zero returns.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_div)                    state_next = DIV_IT;
                    else if (in_mul && !FAST_MUL)  state_next = MUL_IT;
                end
            end
            MUL_IT, DIV_IT: begin
                if (iFlush || (cnt == '0)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, counter, HI/LO writes and done pulse.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt    <= '0;
            op_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            a_q    <= '0;
            dvs_q  <= '0;
            wk_hi  <= '0;
            wk_lo  <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= iOp;
                        a_q    <= iA;
                        q_neg  <= sgn & (iA[WIDTH-1] ^ iB[WIDTH-1]);
                        r_neg  <= sgn & iA[WIDTH-1];
                        b_zero <= (iB == '0);
                        if (in_div) begin
                            wk_hi <= '0;
                            wk_lo <= a_mag;
                            dvs_q <= b_mag;
                            cnt   <= CW'(WIDTH - 1);
                        end else if (in_mul) begin
                            if (FAST_MUL) begin
                                {hi, lo} <= mac(iOp, {hi, lo}, mul_prod);
                                done_q   <= 1'b1;
                            end else begin
                                wk_hi <= '0;
                                wk_lo <= b_mag;
                                dvs_q <= a_mag;
                                cnt   <= CW'(WIDTH - 1);
                            end
                        end else if (iOp == OP_MTHI) begin
                            hi <= iA;
                        end else if (iOp == OP_MTLO) begin
                            lo <= iA;
                        end
                    end
                end
                MUL_IT: begin
                    if (iFlush) begin
                        cnt <= '0;
                    end else begin
                        wk_hi <= mul_hi_n;
                        wk_lo <= mul_lo_n;
                        if (cnt == '0) begin
                            {hi, lo} <= mac(op_q, {hi, lo}, mul_prod);
                            done_q   <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                DIV_IT: begin
                    if (iFlush) begin
                        cnt <= '0;
                    end else begin
                        wk_hi <= rem_n;
                        wk_lo <= quo_n;
                        if (cnt == '0) begin
                            hi     <= div_hi;
                            lo     <= div_lo;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, start_f, flush;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy, done, busy_f, done_f;
    logic [31:0] hi, lo, hi_f, lo_f;
    int          errors = 0;
    int          checks = 0;
    int          nbusy;
    int          ndone;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b0)) dut (
        .iCLK(clk), .iRST(rst), .iStart(start), .iOp(op), .iA(a), .iB(b),
        .iFlush(flush), .oBusy(busy), .oDone(done), .oHI(hi), .oLO(lo)
    );

    muldiv_unit #(.WIDTH(32), .FAST_MUL(1'b1)) dut_f (
        .iCLK(clk), .iRST(rst), .iStart(start_f), .iOp(op), .iA(a), .iB(b),
        .iFlush(flush), .oBusy(busy_f), .oDone(done_f), .oHI(hi_f), .oLO(lo_f)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic issue_f(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start_f = 1'b1;
        step();
        start_f = 1'b0;
    endtask

    // Counts busy cycles until done is seen (bounded); leaves us in the done cycle.
    task automatic run_wait(output int nb);
        nb = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (busy) nb++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_f = 1'b0; flush = 1'b0;
        op = 4'd0; a = '0; b = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        step(); step();
        rst = 1'b0;
        step();

        // DIV -7 / 2
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        run_wait(nbusy);
        check("div_busy_cycles", nbusy, 32);
        check("div_done", done, 1);
        check("div_done_busy", busy, 0);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        step();
        check("div_done_once", done, 0);

        // DIVU by zero
        issue(OP_DIVU, 32'd7, 32'd0);
        run_wait(nbusy);
        check("dz_busy_cycles", nbusy, 32);
        check("dz_lo", lo, 32'hFFFFFFFF);
        check("dz_hi", hi, 32'd7);
        step();

        // Signed overflow
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_wait(nbusy);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'd0);
        step();

        // MTHI / MTLO, then MADD and MSUBU
        issue(OP_MTHI, 32'd0, 32'd0);
        check("mthi_hi", hi, 0);
        check("mthi_busy", busy, 0);
        issue(OP_MTLO, 32'd5, 32'd0);
        check("mtlo_lo", lo, 5);
        check("mtlo_nodone", done, 0);
        issue(OP_MADD, 32'hFFFFFFFE, 32'd3);
        run_wait(nbusy);
        check("madd_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
        step();
        issue(OP_MSUBU, 32'd1, 32'd1);
        run_wait(nbusy);
        check("msubu_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        step();

        // Unknown op leaves HI/LO alone
        issue(4'hF, 32'h12345678, 32'd1);
        check("unk_busy", busy, 0);
        check("unk_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);

        // MULTU iterative vs fast
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_wait(nbusy);
        check("multu_busy_cycles", nbusy, 32);
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        step();
        issue_f(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("fmultu_hilo", {hi_f, lo_f}, 64'hFFFFFFFE_00000001);
        check("fmultu_done", done_f, 1);
        check("fmultu_busy", busy_f, 0);
        step();
        check("fmultu_done_once", done_f, 0);
        issue_f(OP_MULT, 32'hFFFFFFFD, 32'd5);
        check("fmult_hilo", {hi_f, lo_f}, 64'hFFFFFFFF_FFFFFFF1);

        // Flush on busy cycle 10
        issue(OP_DIV, 32'd100, 32'd3);
        for (int i = 0; i < 9; i++) step();
        check("flush_busy_before", busy, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle", busy, 0);
        check("flush_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            step();
        end
        check("flush_no_done", ndone, 0);
        check("flush_hilo_later", {hi, lo}, 64'hFFFFFFFE_00000001);

        // Reset on busy cycle 10
        issue(OP_DIV, 32'd100, 32'd3);
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        #1;
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();

        // Start while busy is dropped; start in the done cycle is accepted
        issue(OP_DIV, 32'd100, 32'd7);
        op = OP_DIVU; a = 32'd9; b = 32'd2; start = 1'b1;
        for (int i = 0; i < 4; i++) step();
        start = 1'b0;
        run_wait(nbusy);
        check("busy_drop_cycles", nbusy, 28);
        check("busy_drop_lo", lo, 32'd14);
        check("busy_drop_hi", hi, 32'd2);
        check("busy_drop_done", done, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("second_busy", busy, 1);
        run_wait(nbusy);
        check("second_busy_cycles", nbusy, 32);
        check("second_lo", lo, 32'd4);
        check("second_hi", hi, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
